// File: rtl/parity_pkg.sv
// parity_pkg: parity-state and link-health encodings shared by the checker and monitor stages.
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        ST_GOOD    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ALARM   = 2'd2
    } link_st_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at MAX, with synchronous reset and clear.
module sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr)
            r_q <= '0;
        else if (inc && r_q != MAX)
            r_q <= r_q + 1'b1;
    end

    assign q = r_q;

endmodule

// File: rtl/parity_err_monitor.sv
// parity_err_monitor: frame/error statistics, error-run tracking and link-health FSM
// fed by the registered result of the parity checker.
module parity_err_monitor
    import parity_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int ERR_THRESH     = 3,
    parameter int RECOVER_THRESH = 4,
    parameter int RUN_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    input  logic             parity_ok,
    input  logic             clr,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [RUN_W-1:0] err_run,
    output logic [1:0]       link_state,
    output logic             alarm,
    output logic             err_pulse
);

    logic             w_acc;
    logic             w_bad;
    logic             w_good;
    logic             w_err_hit;
    logic             w_good_hit;
    logic [RUN_W-1:0] w_good_run;
    link_st_e         r_state;
    link_st_e         w_nxt;
    logic             r_alarm;
    logic             r_err_pulse;

    // a result coinciding with clr is discarded
    assign w_acc  = res_valid && !clr;
    assign w_bad  = w_acc && !parity_ok;
    assign w_good = w_acc && parity_ok;

    sat_counter #(.W(CNT_W)) u_frame (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_acc), .q(frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err (
        .clk(clk), .rst(rst), .clr(clr), .inc(w_bad), .q(err_cnt)
    );

    sat_counter #(.W(RUN_W), .MAX(RUN_W'(ERR_THRESH))) u_err_run (
        .clk(clk), .rst(rst), .clr(clr || w_good), .inc(w_bad), .q(err_run)
    );

    sat_counter #(.W(RUN_W), .MAX(RUN_W'(RECOVER_THRESH))) u_good_run (
        .clk(clk), .rst(rst), .clr(clr || w_bad), .inc(w_good), .q(w_good_run)
    );

    // thresholds judged on the run lengths as they will be after this accept
    assign w_err_hit  = w_bad && err_run >= RUN_W'(ERR_THRESH - 1);
    assign w_good_hit = w_good && w_good_run >= RUN_W'(RECOVER_THRESH - 1);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_GOOD:    w_nxt = w_bad ? ST_SUSPECT : ST_GOOD;
            ST_SUSPECT: w_nxt = w_err_hit ? ST_ALARM : (w_good ? ST_GOOD : ST_SUSPECT);
            ST_ALARM:   w_nxt = w_good_hit ? ST_GOOD : ST_ALARM;
            default:    w_nxt = ST_GOOD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= ST_GOOD;
            r_alarm     <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_alarm     <= w_nxt == ST_ALARM;
            r_err_pulse <= w_bad;
        end
    end

    assign link_state = r_state;
    assign alarm      = r_alarm;
    assign err_pulse  = r_err_pulse;

endmodule

// File: doc/parity_err_monitor.md
Name: parity_err_monitor

Overview:
- Downstream stage of the 3-bit parity checker; consumes its registered result (parity_ok) together with a result strobe.
- Accumulates frame and error statistics, tracks runs of consecutive errors/good frames, and drives a three-state link-health FSM with an alarm output.
- Sits between the checker and the status/CSR logic; all outputs are registered.

Parameters:
- CNT_W, 16, width of frame and error counters (saturating).
- ERR_THRESH, 3, consecutive bad results that force ALARM (must be >= 2).
- RECOVER_THRESH, 4, consecutive good results that return ALARM to GOOD (must be >= 1).
- RUN_W, 4, width of run-length counters; must hold max(ERR_THRESH, RECOVER_THRESH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  result strobe: the checker's valid delayed one cycle, aligned with parity_ok.
- parity_ok  in  1  checker result, sampled only when res_valid=1.
- clr  in  1  synchronous clear of counters and FSM, single-cycle pulse.
- frame_cnt  out  CNT_W  number of results accepted since reset/clr.
- err_cnt  out  CNT_W  number of results with parity_ok=0.
- err_run  out  RUN_W  current consecutive-error run length.
- link_state  out  2  0=GOOD, 1=SUSPECT, 2=ALARM (3 never driven).
- alarm  out  1  high while link_state==ALARM.
- err_pulse  out  1  one-cycle pulse per accepted bad result.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all counters 0, link_state=GOOD, alarm=0, err_pulse=0, internal good run=0.
- Accept: result accepted on a rising edge where res_valid=1 and clr=0; parity_ok is ignored when res_valid=0.
- Latency: every output reflects an accepted result one cycle after the accepting edge.
- frame_cnt increments on every accept. err_cnt increments on every accept with parity_ok=0.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- err_run: +1 on bad accept, saturating at ERR_THRESH; cleared to 0 on good accept.
- good_run (internal): +1 on good accept, saturating at RECOVER_THRESH; cleared to 0 on bad accept.
- err_pulse=1 for exactly one cycle after each bad accept, otherwise 0. Back-to-back bad results give continuous high.
- FSM transitions, evaluated on accept using post-update run values:
  - GOOD: bad -> SUSPECT; good -> GOOD.
  - SUSPECT: err_run reaches ERR_THRESH -> ALARM; good -> GOOD; bad below threshold -> SUSPECT.
  - ALARM: good_run reaches RECOVER_THRESH -> GOOD; otherwise stays ALARM. No ALARM->SUSPECT path.
- No accept means no change: state and counters hold.
- alarm is registered, equals (next link_state==ALARM), and asserts in the same cycle link_state shows ALARM.
- clr: same effect as rst on all outputs and internal state. A coincident res_valid result is discarded, not counted.
- clr and rst both high: identical outcome (reset values).
- rst mid-run: all state is lost; the next accept is treated as the first frame.

Decomposition:
- Shared package parity_pkg: link-state encoding constants (ST_GOOD=2'd0, ST_SUSPECT=2'd1, ST_ALARM=2'd2).
- The same package also holds the even/odd parity-state constants already used by the checker, so both stages share one definition.
- One natural sub-module, sat_counter (parameterised width, inc, clr, saturating). Instantiate it for frame_cnt, err_cnt, err_run and good_run.
- FSM stays in the top module.

Test Plan:
- Reset then 5 good results -> frame_cnt=5, err_cnt=0, err_run=0, link_state=GOOD, alarm=0, err_pulse never high.
- good, bad, good -> after bad: link_state=SUSPECT, err_run=1, err_pulse high for one cycle. After the final good: GOOD, err_cnt=1, frame_cnt=3.
- 3 consecutive bad (ERR_THRESH=3) -> link_state and alarm change one cycle after the 3rd accept: ALARM, alarm=1, err_run=3. A 4th bad keeps err_run=3 and err_cnt=4.
- From ALARM: good x3, bad, good x4 -> alarm stays 1 through the first 7 results and drops one cycle after the 8th; good_run restarts after the bad result.
- res_valid=0 with parity_ok toggling for 10 cycles -> no output changes. clr asserted together with a bad res_valid -> all counters 0, GOOD, err_pulse=0.
- CNT_W=4 override, 20 bad results with ERR_THRESH=3 -> frame_cnt=15, err_cnt=15 (saturated, no wrap). Assert rst mid-stream -> all outputs return to reset values on the next edge.
